ordinator_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one serial 8-bit calculator datapath (the ordinator) between several requesters. Each granted requester streams an expression as alternating number/operator tokens, terminated by EQL or ERR. The block clears the datapath, forwards the tokens, waits for the datapath's `ready`, and returns the result to that requester. It sits between the requester front-ends and the single calculator instance.

---
 rtl/ord_pkg.sv | 13 +
 rtl/ord_rr_pick.sv | 28 ++
 rtl/ordinator_arb.sv | 93 +++++++++
 tb/tb_ordinator_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ord_pkg.sv
// ord_pkg: shared operator codes, arbiter state encoding and helpers for the ordinator arbiter
package ord_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [7:0] OPERATOR_ADD = 8'd0;
  localparam logic [7:0] OPERATOR_SUB = 8'd1;
  localparam logic [7:0] OPERATOR_EQL = 8'd2;
  localparam logic [7:0] OPERATOR_ERR = 8'd3;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, DONE, ABORT} arb_state_t;
  function automatic logic is_term(input logic [7:0] t);
    return t == OPERATOR_EQL || t == OPERATOR_ERR;
  endfunction
endpackage

// File: rtl/ord_rr_pick.sv
// ord_rr_pick: combinational rotate-priority picker, first set request at or above ptr with wrap
module ord_rr_pick
  import ord_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // Walk from the farthest offset down so the nearest request to ptr is the last writer
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = TRUE;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/ordinator_arb.sv
// ordinator_arb: round-robin arbiter/sequencer sharing one serial calculator datapath among N_REQ requesters
// Optional WAIT watchdog with timeout result is built when ORD_ARB_TIMEOUT_EN is defined.
module ordinator_arb
  import ord_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   tok_valid,
  input  logic [8*N_REQ-1:0] tok_data,
  output logic [N_REQ-1:0]   tok_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [7:0]         resp_data,
  output logic               resp_err,
  output logic [7:0]         calc_in,
  output logic               calc_en,
  output logic               calc_clr,
  input  logic [7:0]         calc_result,
  input  logic               calc_ready
);
  localparam int IW = $clog2(N_REQ);
  arb_state_t state, nxt;
  logic [IW-1:0] ptr, g, idx_p;
  logic [N_REQ-1:0] gnt_p, g_oh;
  logic op_pos, own_req, accept, rdy, to_hit;
  logic [7:0] tok;
  ord_rr_pick #(.N(N_REQ)) u_pick (.req(req), .ptr(ptr), .gnt(gnt_p), .idx(idx_p));
  assign own_req = req[g];
  assign tok = tok_data[{g, 3'b000} +: 8];
  assign accept = state == FEED && own_req && tok_valid[g];
  // calc_en high means the terminator is only now reaching the datapath, so ready is stale
  assign rdy = calc_ready && !calc_en;
  assign grant = state != IDLE ? g_oh : '0;
  assign tok_ready = state == FEED && own_req ? g_oh : '0;
  assign resp_valid = state == DONE ? g_oh : '0;
  assign calc_clr = state == CLEAR || state == ABORT || (state == DONE && resp_err);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? CLEAR : IDLE;
      CLEAR:   nxt = FEED;
      FEED:    nxt = !own_req ? ABORT : accept && op_pos && is_term(tok) ? WAIT : FEED;
      WAIT:    nxt = !own_req ? ABORT : rdy || to_hit ? DONE : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      g_oh <= '0;
      op_pos <= FALSE;
      calc_in <= '0;
      calc_en <= FALSE;
      resp_data <= '0;
    end else begin
      state <= nxt;
      calc_en <= accept;
      if (accept) calc_in <= tok;
      op_pos <= state == CLEAR ? FALSE : accept ? ~op_pos : op_pos;
      if (state == IDLE) begin
        g <= idx_p;
        g_oh <= gnt_p;
      end
      if (state == DONE || state == ABORT) ptr <= g == IW'(N_REQ - 1) ? '0 : g + 1'b1;
      if (state == WAIT && nxt == DONE) resp_data <= to_hit ? 8'd0 : calc_result;
    end
  end
`ifdef ORD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic err_q;
  assign to_hit = state == WAIT && !rdy && cnt == CW'(TIMEOUT_CYC - 1);
  assign resp_err = err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      err_q <= FALSE;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == WAIT && nxt == DONE) err_q <= to_hit;
    end
  end
`else
  assign to_hit = FALSE;
  assign resp_err = FALSE;
`endif
endmodule

// File: tb/tb_ordinator_arb.sv
// tb_ordinator_arb: table-driven transactions against a serial calculator model, with token/response scoreboards
module tb_ordinator_arb;
  typedef struct { int r; int n; logic [7:0] t [6]; logic [7:0] res; } vec_t;
  typedef struct { logic [3:0] v; logic [7:0] d; logic e; } resp_t;
  logic clk = 0, reset = 0;
  logic [3:0] req = 0, tok_valid = 0;
  logic [31:0] tok_data = 0;
  logic [3:0] tok_ready, grant, resp_valid;
  logic [7:0] resp_data, calc_in;
  logic resp_err, calc_en, calc_clr;
  logic [7:0] calc_result = 0;
  logic calc_ready = 0;
  logic [7:0] exp_tok [$];
  resp_t exp_resp [$];
  int n_chk = 0, n_fail = 0, n_resp = 0, clr_cnt = 0;
  logic [7:0] acc = 0, op = 0;
  logic num = 1, mute = 0;
  int cd = 0;
  vec_t tbl [4];

  ordinator_arb #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .req(req), .tok_valid(tok_valid), .tok_data(tok_data),
    .tok_ready(tok_ready), .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .calc_in(calc_in), .calc_en(calc_en), .calc_clr(calc_clr),
    .calc_result(calc_result), .calc_ready(calc_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int r);
    return 4'(1 << r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Serial calculator: number/operator alternation, ready four cycles after the terminator
  always @(posedge clk) begin
    #1;
    if (!reset || calc_clr) begin
      acc = 0; op = 0; num = 1; cd = 0; calc_ready = 0;
    end else if (calc_en) begin
      if (num) acc = (op == 8'd1) ? acc - calc_in : acc + calc_in;
      else begin
        op = calc_in;
        if (calc_in == 8'd2 || calc_in == 8'd3) cd = mute ? 0 : 4;
      end
      num = !num;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin calc_ready = 1; calc_result = acc; end
    end
  end

  always @(posedge clk) begin
    resp_t e;
    #1;
    if (reset) begin
      if (calc_clr) clr_cnt++;
      if (calc_en) begin
        if (exp_tok.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL calc_in_unexpected: got 0x%0h, required no token", calc_in);
        end else chk("calc_in", calc_in, exp_tok.pop_front());
      end
      if (resp_valid != 0) begin
        n_resp++;
        if (exp_resp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL resp_unexpected: got resp_valid 0x%0h, required none", resp_valid);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_valid", resp_valid, e.v);
          chk("resp_data", resp_data, e.d);
          chk("resp_err", resp_err, e.e);
          chk("resp_clr", calc_clr, e.e);
        end
      end
    end
  end

  task automatic get_grant(input int r);
    int k = 0;
    while (grant == 0 && k < 20) begin @(negedge clk); k++; end
    chk("grant", grant, oh(r));
  endtask

  task automatic send_tok(input int r, input logic [7:0] v);
    int k = 0;
    tok_data[r*8 +: 8] = v;
    tok_valid[r] = 1;
    exp_tok.push_back(v);
    #1;
    while (!tok_ready[r] && k < 20) begin @(negedge clk); #1; k++; end
    chk("tok_ready", tok_ready, oh(r));
    @(negedge clk);
    tok_valid[r] = 0;
  endtask

  task automatic finish_txn(input int r, input int base);
    int k = 0;
    while (n_resp == base && k < 80) begin @(negedge clk); k++; end
    chk("resp_seen", n_resp, base + 1);
    req[r] = 0;
    @(negedge clk);
    chk("grant_drop", grant, 0);
  endtask

  task automatic run_txn(input vec_t v, input logic err);
    int base = n_resp;
    exp_resp.push_back('{oh(v.r), err ? 8'd0 : v.res, err});
    @(negedge clk);
    req[v.r] = 1;
    get_grant(v.r);
    for (int i = 0; i < v.n; i++) send_tok(v.r, v.t[i]);
    finish_txn(v.r, base);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, base;
    tbl[0] = '{0, 4, '{8'd5, 8'd0, 8'd3, 8'd2, 8'd0, 8'd0}, 8'd8};
    tbl[1] = '{2, 4, '{8'd2, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0}, 8'd1};
    tbl[2] = '{1, 6, '{8'd10, 8'd1, 8'd3, 8'd0, 8'd4, 8'd3}, 8'd11};
    tbl[3] = '{3, 4, '{8'd200, 8'd0, 8'd100, 8'd2, 8'd0, 8'd0}, 8'd44};
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_calc_in", calc_in, 0);
    chk("rst_calc_en", calc_en, 0);
    chk("rst_calc_clr", calc_clr, 0);
    reset = 1;
    @(negedge clk);
    req = 4'b0110;
    run_txn('{1, 4, '{8'd5, 8'd0, 8'd3, 8'd2, 8'd0, 8'd0}, 8'd8}, 0);
    run_txn('{2, 2, '{8'd7, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd7}, 0);
    req = 4'b1001;
    run_txn('{3, 2, '{8'd9, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd9}, 0);
    run_txn('{0, 2, '{8'd4, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd4}, 0);
`ifdef ORD_ARB_TIMEOUT_EN
    mute = 1;
    run_txn('{0, 2, '{8'd6, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd6}, 1);
    mute = 0;
`endif
    for (int i = 0; i < 4; i++) run_txn(tbl[i], 0);
    @(negedge clk);
    req = 4'b0011;
    get_grant(0);
    send_tok(0, 8'd5);
    send_tok(0, 8'd0);
    clr_cnt = 0;
    base = n_resp;
    req[0] = 0;
    k = 0;
    while (grant != 0 && k < 20) begin @(negedge clk); k++; end
    chk("abort_clr", clr_cnt, 1);
    chk("abort_no_resp", n_resp, base);
    run_txn('{1, 4, '{8'd8, 8'd1, 8'd3, 8'd2, 8'd0, 8'd0}, 8'd5}, 0);
    @(negedge clk);
    req = 4'b1001;
    get_grant(3);
    send_tok(3, 8'h55);
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_tok_ready", tok_ready, 0);
    chk("arst_calc_en", calc_en, 0);
    chk("arst_calc_in", calc_in, 0);
    chk("arst_calc_clr", calc_clr, 0);
    chk("arst_resp_valid", resp_valid, 0);
    exp_tok.delete();
    exp_resp.delete();
    @(negedge clk);
    reset = 1;
    get_grant(0);
    req = 0;
    k = 0;
    while (grant != 0 && k < 20) begin @(negedge clk); k++; end
    chk("final_idle", grant, 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
